// File: rtl/clock_pkg.sv
// clock_pkg: shared definitions for the HH:MM:SS time-keeping controller.
//   state_e       one-hot mode encoding, driven directly on the set[2:0] output
//   *_MAX         largest legal BCD value of each time field
//   bcd_inc/dec   single-step BCD arithmetic without range wrap (callers wrap)
package clock_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'b001,
        ST_SET_MIN  = 3'b010,
        ST_SET_HOUR = 3'b100
    } state_e;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    // Units digit rolls 9->0 and carries into the tens digit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else                r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Units digit rolls 0->9 and borrows from the tens digit.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
        else                r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/bcd2_updown.sv
// bcd2_updown: two-digit BCD up/down register with wrap at MAX.
//   clk, rst      clock, synchronous active-high reset (loads RST_VAL)
//   inc, dec      step up / down; inc wins if both are asserted
//   clr           force 00 (highest priority after rst)
//   load,load_val parallel load of a legal BCD value
//   q             current BCD value, always 00..MAX
//   carry         high in the cycle an accepted inc wraps MAX->00; lets
//                 the next field step on the same clock edge
module bcd2_updown
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX     = 8'h59,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] q,
    output logic       carry
);

    assign carry = inc && !clr && !load && (q == MAX);

    always_ff @(posedge clk) begin
        if (rst)       q <= RST_VAL;
        else if (clr)  q <= 8'h00;
        else if (load) q <= load_val;
        else if (inc)  q <= (q == MAX)   ? 8'h00 : bcd_inc(q);
        else if (dec)  q <= (q == 8'h00) ? MAX   : bcd_dec(q);
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time keeping plus RUN / SET_MIN / SET_HOUR mode control.
//   clk, rst        clock, synchronous active-high reset
//   tick_1hz        1-cycle pulse per second
//   tick_blink      1-cycle pulse at the flash toggle rate
//   key_mode/inc/dec 1-cycle debounced key pulses
//   set[2:0]        one-hot mode (001 RUN, 010 SET_MIN, 100 SET_HOUR); this
//                   is the FSM state register itself, so it doubles as the
//                   observable state
//   blink           digit-visible gate for the flashing field (1 = visible)
//   hour/min/sec_bcd BCD time fields
// Interface semantics: every input is a single-cycle pulse with no
// handshake; a pulse is consumed on the edge where it is high and its
// effect is visible on the registered outputs right after that edge.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_S = 10,
    parameter logic [7:0]  RST_HOUR  = 8'h12,
    parameter logic [7:0]  RST_MIN   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_blink,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_dec,
    output logic [2:0] set,
    output logic       blink,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_S);

    state_e     state_q, state_d;
    logic       blink_q, blink_d;
    logic [7:0] idle_q, idle_d;

    logic in_run, in_set_min, in_set_hour;
    logic any_key, adj_inc, adj_dec, timeout;
    logic sec_carry, min_carry, unused_hour_carry;

    assign in_run      = (state_q == ST_RUN);
    assign in_set_min  = (state_q == ST_SET_MIN);
    assign in_set_hour = (state_q == ST_SET_HOUR);

    assign any_key = key_mode | key_inc | key_dec;
    // Mode beats inc/dec; inc together with dec cancels out.
    assign adj_inc = key_inc & ~key_dec & ~key_mode;
    assign adj_dec = key_dec & ~key_inc & ~key_mode;
    // A key in the same cycle restarts the idle count instead.
    assign timeout = !in_run && (idle_q == TIMEOUT_CNT) && !any_key;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:      if (key_mode) state_d = ST_SET_MIN;
            ST_SET_MIN:  if (key_mode) state_d = ST_SET_HOUR;
                         else if (timeout) state_d = ST_RUN;
            ST_SET_HOUR: if (key_mode || timeout) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    always_comb begin
        blink_d = blink_q;
        if (state_d != state_q || in_run) blink_d = 1'b1;
        else if (adj_inc || adj_dec)      blink_d = 1'b1;
        else if (tick_blink)              blink_d = ~blink_q;
    end

    always_comb begin
        idle_d = idle_q;
        if (state_d != state_q || any_key || in_run) idle_d = 8'd0;
        else if (tick_1hz && idle_q != TIMEOUT_CNT)  idle_d = idle_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            blink_q <= 1'b1;
            idle_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            blink_q <= blink_d;
            idle_q  <= idle_d;
        end
    end

    // Seconds only run in RUN; entering SET_MIN zeroes them so the clock
    // resumes from :00 after setting.
    bcd2_updown #(.MAX(SEC_MAX), .RST_VAL(8'h00)) u_sec (
        .clk      (clk),
        .rst      (rst),
        .inc      (in_run && tick_1hz && !key_mode),
        .dec      (1'b0),
        .clr      (in_run && key_mode),
        .load     (1'b0),
        .load_val (8'h00),
        .q        (sec_bcd),
        .carry    (sec_carry)
    );

    // Carries only chain in RUN; manual adjust of one field never ripples.
    bcd2_updown #(.MAX(MIN_MAX), .RST_VAL(RST_MIN)) u_min (
        .clk      (clk),
        .rst      (rst),
        .inc      ((in_run && sec_carry) || (in_set_min && adj_inc)),
        .dec      (in_set_min && adj_dec),
        .clr      (1'b0),
        .load     (1'b0),
        .load_val (8'h00),
        .q        (min_bcd),
        .carry    (min_carry)
    );

    bcd2_updown #(.MAX(HOUR_MAX), .RST_VAL(RST_HOUR)) u_hour (
        .clk      (clk),
        .rst      (rst),
        .inc      ((in_run && min_carry) || (in_set_hour && adj_inc)),
        .dec      (in_set_hour && adj_dec),
        .clr      (1'b0),
        .load     (1'b0),
        .load_val (8'h00),
        .q        (hour_bcd),
        .carry    (unused_hour_carry)
    );

    assign set   = state_q;
    assign blink = blink_q;

endmodule
